seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameters SHALL be:
- SETTLE, default 4: cycles an/seg must hold stable before a digit is sampled.
- TIMEOUT, default 262143: cycles without a valid frame before stale asserts.

REQ-002 Ports SHALL be:
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- an  input  4  anode selects, active-low.
- seg  input  7  cathode pattern, active-low, bit6=g .. bit0=a.
- dp  input  1  decimal point, ignored.
- value  output  4  recovered two's-complement digit value, -8..+7.
- valid  output  1  one-cycle pulse when value updates.
- err  output  1  one-cycle pulse on an undecodable sample or illegal anode.
- err_cnt  output  8  saturating error count.
- stale  output  1  high when no valid frame has arrived within TIMEOUT cycles.

Function
REQ-003 The block SHALL register an and seg once per cycle, an_q/seg_q, before any comparison.
REQ-004 The settle counter SHALL reset to 0 whenever an_q or seg_q differs from its previous-cycle value, else increment, saturating at SETTLE.
REQ-005 A sample SHALL occur exactly once per dwell, in the cycle the counter reaches SETTLE-1; no resample until an_q or seg_q changes.
REQ-006 Anode handling:
- 1110 is the magnitude digit.
- 1101 is the sign digit.
- 1111 is blank: no sample, no error.
- Any other code at sample time SHALL pulse err and discard the sample.
REQ-007 Magnitude decode (seg -> mag):
- 1000000=0, 1111001=1, 0100100=2, 0110000=3
- 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8
- Any other pattern SHALL pulse err, set mag_ok=0.
REQ-008 Sign decode (seg -> neg):
- 0111111 gives neg=1.
- 1111111 gives neg=0.
- Any other pattern SHALL pulse err, set sign_ok=0.
REQ-009 Frame FSM states SHALL be EMPTY, HAVE_SIGN, HAVE_MAG; order of arrival is irrelevant.
- EMPTY -> HAVE_SIGN on a good sign sample.
- EMPTY -> HAVE_MAG on a good magnitude sample.
- HAVE_SIGN or HAVE_MAG plus a good sample of the other digit -> combine, return to EMPTY.
- A repeated sample of the same digit SHALL overwrite the held copy.
REQ-010 Combine rules:
- neg=0 and mag 0..7: value=mag.
- neg=1 and mag 1..8: value=-mag mod 16, e.g. mag 8 -> 1000, mag 1 -> 1111.
- neg=0 with mag 8, or neg=1 with mag 0: SHALL pulse err, no valid, FSM -> EMPTY.
REQ-011 On a good combine, valid SHALL pulse and value update in the cycle after the completing sample; value SHALL hold between pulses.
REQ-012 Any err SHALL increment err_cnt, saturating at 255.
- An err from a bad sample SHALL return the FSM to EMPTY.
- err and valid SHALL never assert in the same cycle.
REQ-013 The timeout counter SHALL clear on each valid pulse.
- It increments otherwise, saturating.
- stale SHALL assert when it reaches TIMEOUT and deassert in the cycle valid pulses.

Reset
REQ-014 While rst is high, all outputs and state SHALL go immediately to reset values: value=0000, valid=0, err=0, err_cnt=0, stale=0, FSM=EMPTY, counters=0, an_q=1111, seg_q=1111111.
REQ-015 A partially captured frame SHALL be discarded on reset; the first post-reset valid requires fresh sign and magnitude samples.

Verification
REQ-016 Positive 5: an 1101/seg 1111111 then an 1110/seg 0010010, each dwelling 20 cycles -> one valid pulse, value=0101, err_cnt=0.
REQ-017 Negative 8: alternate sign 0111111 and magnitude 0000000 repeatedly -> value=1000 each frame, one valid per sign+mag pair.
REQ-018 Glitch: seg changes every 2 cycles with SETTLE=4 -> no sample, no valid, no err.
REQ-019 Illegal input:
- an=1100 held 10 cycles -> one err pulse, err_cnt=1.
- sign blank with mag 0000000 -> err, err_cnt=2, no valid.
REQ-020 Reset mid-frame: assert rst after a good sign sample, release, then send only magnitude 0000010 -> no valid until a sign sample follows.
REQ-021 Timeout with TIMEOUT=100:
- 1111 on an for 150 cycles -> stale=1 at cycle 100.
- A subsequent good frame -> stale=0 with valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Recovers a signed 4-bit digit from a multiplexed two-digit 7-segment scan (sign + magnitude).
// Samples each stable dwell once, pairs sign and magnitude in any order, and flags bad input.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 262143
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] value,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       stale
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    EMPTY,
    HAVE_SIGN,
    HAVE_MAG
  } frame_e;

  logic [3:0]    an_q, an_p_q;
  logic [6:0]    seg_q, seg_p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  frame_e        state_q, state_d;
  logic          neg_q, neg_d;
  logic [3:0]    mag_q, mag_d;
  logic [3:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          stale_q, stale_d;

  logic          stable, sample;
  logic          mag_ok, sign_ok, neg;
  logic [3:0]    mag;
  logic          do_combine, c_neg, legal;
  logic [3:0]    c_mag;
  logic          dp_unused;

  assign dp_unused = dp;

  // The dwell counter measures how long the registered inputs have matched their previous copy.
  always_comb begin
    stable = (an_q == an_p_q) && (seg_q == seg_p_q);
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    sample = stable && (cnt_q == SETTLE_LAST);
  end

  always_comb begin
    mag_ok = 1'b1;
    mag    = '0;
    case (seg_q)
      7'b1000000: mag = 4'd0;
      7'b1111001: mag = 4'd1;
      7'b0100100: mag = 4'd2;
      7'b0110000: mag = 4'd3;
      7'b0011001: mag = 4'd4;
      7'b0010010: mag = 4'd5;
      7'b0000010: mag = 4'd6;
      7'b1111000: mag = 4'd7;
      7'b0000000: mag = 4'd8;
      default:    mag_ok = 1'b0;
    endcase
    sign_ok = 1'b1;
    neg     = 1'b0;
    case (seg_q)
      7'b0111111: neg = 1'b1;
      7'b1111111: neg = 1'b0;
      default:    sign_ok = 1'b0;
    endcase
  end

  // Completing digit supplies its freshly decoded half; the other half comes from the held copy.
  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    mag_d      = mag_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    do_combine = 1'b0;
    c_neg      = neg_q;
    c_mag      = mag_q;
    legal      = 1'b0;
    if (sample) begin
      case (an_q)
        4'b1110: begin
          if (!mag_ok) begin
            err_d = 1'b1;
          end else if (state_q == HAVE_SIGN) begin
            do_combine = 1'b1;
            c_mag      = mag;
          end else begin
            mag_d   = mag;
            state_d = HAVE_MAG;
          end
        end
        4'b1101: begin
          if (!sign_ok) begin
            err_d = 1'b1;
          end else if (state_q == HAVE_MAG) begin
            do_combine = 1'b1;
            c_neg      = neg;
          end else begin
            neg_d   = neg;
            state_d = HAVE_SIGN;
          end
        end
        4'b1111: ;
        default: err_d = 1'b1;
      endcase
    end
    if (do_combine) begin
      legal = c_neg ? (c_mag != 4'd0) : (c_mag != 4'd8);
      if (legal) begin
        valid_d = 1'b1;
        value_d = c_neg ? (4'd0 - c_mag) : c_mag;
      end else begin
        err_d = 1'b1;
      end
    end
    if (err_d || do_combine) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    if (valid_d) begin
      tmo_d   = '0;
      stale_d = 1'b0;
    end else begin
      tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : (tmo_q + TW'(1));
      stale_d = (tmo_d == TMO_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q      <= '1;
      seg_q     <= '1;
      an_p_q    <= '1;
      seg_p_q   <= '1;
      cnt_q     <= '0;
      state_q   <= EMPTY;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      tmo_q     <= '0;
      stale_q   <= 1'b0;
    end else begin
      an_q      <= an;
      seg_q     <= seg;
      an_p_q    <= an_q;
      seg_p_q   <= seg_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      neg_q     <= neg_d;
      mag_q     <= mag_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      tmo_q     <= tmo_d;
      stale_q   <= stale_d;
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign stale   = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a digit-level model predicts valid/err events per dwell,
// and an independent monitor pops and compares them whenever the DUT pulses.
module tb_seg_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] an  = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic       dp  = 1'b0;
  logic [3:0] value;
  logic       valid, err, stale;
  logic [7:0] err_cnt;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
    .value(value), .valid(valid), .err(err), .err_cnt(err_cnt), .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int val;
    int ecnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  hold_val = 0;

  logic [6:0] mag_tbl [9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};

  // Digit-level model state
  bit         m_have_sign, m_have_mag, m_neg, sampled;
  int         m_mag, m_errs, run_len;
  logic [3:0] cur_an;
  logic [6:0] cur_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_err();
    ev_t e;
    if (m_errs < 255) m_errs++;
    m_have_sign = 0;
    m_have_mag  = 0;
    e.is_err = 1; e.val = 0; e.ecnt = m_errs;
    exp_q.push_back(e);
  endtask

  task automatic combine(input bit n, input int m);
    ev_t e;
    m_have_sign = 0;
    m_have_mag  = 0;
    if ((n && m >= 1) || (!n && m <= 7)) begin
      e.is_err = 0; e.val = (n ? 16 - m : m) % 16; e.ecnt = m_errs;
      exp_q.push_back(e);
    end else begin
      push_err();
    end
  endtask

  task automatic model_sample(input logic [3:0] a, input logic [6:0] s);
    int m = -1;
    bit n;
    case (a)
      4'hF: ;
      4'hE: begin
        for (int i = 0; i < 9; i++) if (mag_tbl[i] == s) m = i;
        if (m < 0) push_err();
        else if (m_have_sign) combine(m_neg, m);
        else begin m_have_mag = 1; m_mag = m; end
      end
      4'hD: begin
        if (s == 7'b0111111 || s == 7'b1111111) begin
          n = (s == 7'b0111111);
          if (m_have_mag) combine(n, m_mag);
          else begin m_have_sign = 1; m_neg = n; end
        end else begin
          push_err();
        end
      end
      default: push_err();
    endcase
  endtask

  // A held input pattern yields exactly one sample once it has been stable for more than SETTLE cycles.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    if (a == cur_an && s == cur_seg) run_len += len;
    else begin cur_an = a; cur_seg = s; run_len = len; sampled = 0; end
    if (!sampled && run_len >= int'(SETTLE) + 1) begin
      sampled = 1;
      model_sample(a, s);
    end
    an  = a;
    seg = s;
    repeat (len) begin
      dp = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    an  = 4'hF;
    seg = 7'h7F;
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_stale", stale, 0);
    m_have_sign = 0; m_have_mag = 0; m_errs = 0;
    cur_an = 4'hF; cur_seg = 7'h7F; run_len = 1000; sampled = 1;
    hold_val = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Monitor: compares every DUT event against the scoreboard head
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (!rst) begin
      if (valid || err) begin
        check("valid_err_excl", {31'd0, valid && err}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, valid, err}, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            check("err_pulse", {31'd0, err}, 1);
            check("err_cnt", err_cnt, e.ecnt);
            check("value_hold_on_err", value, hold_val);
          end else begin
            check("valid_pulse", {31'd0, valid}, 1);
            check("value", value, e.val);
            check("err_cnt_on_valid", err_cnt, e.ecnt);
            check("stale_on_valid", stale, 0);
            hold_val = e.val;
          end
        end
      end else begin
        check("value_hold", value, hold_val);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         len;
    #1 rst = 1;
    do_reset();

    // Positive 5
    dwell(4'hD, 7'b1111111, 20);
    dwell(4'hE, 7'b0010010, 20);
    drain("r16_drain");
    check("r16_value", value, 5);
    check("r16_errcnt", err_cnt, 0);

    // Negative 8, repeated frames
    for (int i = 0; i < 4; i++) begin
      dwell(4'hD, 7'b0111111, 10);
      dwell(4'hE, 7'b0000000, 10);
    end
    drain("r17_drain");
    check("r17_value", value, 8);

    // Glitching segments never settle
    for (int i = 0; i < 12; i++) dwell(4'hE, (i % 2) ? 7'b1010101 : 7'b0101010, 2);
    drain("r18_drain");
    check("r18_errcnt", err_cnt, 0);

    // Illegal anode, then blank sign with magnitude 8
    dwell(4'hC, 7'h7F, 10);
    drain("r19a_drain");
    check("r19a_errcnt", err_cnt, 1);
    dwell(4'hD, 7'b1111111, 10);
    dwell(4'hE, 7'b0000000, 10);
    drain("r19b_drain");
    check("r19b_errcnt", err_cnt, 2);

    // Reset discards a held sign
    dwell(4'hD, 7'b0111111, 10);
    drain("r20_pre");
    do_reset();
    dwell(4'hE, 7'b0000010, 12);
    drain("r20_novalid");
    dwell(4'hD, 7'b1111111, 10);
    drain("r20_drain");
    check("r20_value", value, 6);

    // Timeout
    do_reset();
    dwell(4'hF, 7'h7F, 95);
    check("r21_stale_before", stale, 0);
    dwell(4'hF, 7'h7F, 10);
    check("r21_stale_after", stale, 1);
    dwell(4'hF, 7'h7F, 45);
    dwell(4'hD, 7'b0111111, 10);
    dwell(4'hE, 7'b1111001, 10);
    drain("r21_drain");
    check("r21_stale_cleared", stale, 0);
    check("r21_value", value, 15);

    // Randomized dwells
    for (int i = 0; i < 300; i++) begin
      do begin
        case ($urandom_range(0, 9))
          0, 1, 2: begin
            a = 4'hE;
            if ($urandom_range(0, 9) < 7) s = mag_tbl[$urandom_range(0, 8)];
            else s = 7'($urandom);
          end
          3, 4, 5: begin
            a = 4'hD;
            case ($urandom_range(0, 9))
              0:       s = 7'($urandom);
              1, 2, 3, 4: s = 7'b0111111;
              default: s = 7'b1111111;
            endcase
          end
          6, 7, 8: begin a = 4'hF; s = 7'($urandom); end
          default: begin
            do a = 4'($urandom); while (a == 4'hE || a == 4'hD || a == 4'hF);
            s = 7'($urandom);
          end
        endcase
      end while (a == cur_an && s == cur_seg);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(8, 14);
      dwell(a, s, len);
    end
    drain("rand_drain");
    check("rand_errcnt", err_cnt, m_errs);

    // Error counter saturation
    for (int i = 0; i < 270; i++) dwell((i % 2) ? 4'hC : 4'hB, 7'h7F, 8);
    drain("sat_drain");
    check("sat_errcnt", err_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
